// File: rtl/adc_capture_pkg.sv
// Shared constants, state encoding and helpers for the ADC frame capture block.
package adc_capture_pkg;

  localparam int NCH_DEF = 8;
  localparam int DW_DEF  = 12;
  // Seven guard bits hold the sum of up to 128 samples without overflow.
  localparam int ACC_W   = DW_DEF + 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

  function automatic logic is_busy(input cap_state_e s);
    return (s == ST_ARMED) || (s == ST_DELAY) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/adc_chan_decim.sv
// One channel's decimation stage: picks the first sample of each window, or, with
// ADC_CAPTURE_AVG_EN defined, forms the boxcar average of the window.
module adc_chan_decim
  import adc_capture_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] sample_i,
  input  logic          win_start_i,
  input  logic          win_end_i,
`ifdef ADC_CAPTURE_AVG_EN
  input  logic [2:0]    dec_log2_i,
`endif
  output logic [DW-1:0] word_o
);

  logic [DW-1:0] word_q;

`ifdef ADC_CAPTURE_AVG_EN
  localparam int AW = DW + (ACC_W - DW_DEF);

  logic [AW-1:0] acc_q, acc_d;

  // The window start restarts the sum, so the accumulator needs no other enable.
  always_comb begin
    acc_d = (win_start_i ? '0 : acc_q) + AW'(sample_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      word_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (win_end_i) word_q <= DW'(acc_d >> dec_log2_i);
    end
  end
`else
  logic [DW-1:0] held_q;
  logic [DW-1:0] pick_w;

  // At D=1 start and end coincide, so the live sample bypasses the holding register.
  always_comb begin
    pick_w = win_start_i ? sample_i : held_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      word_q <= '0;
    end else begin
      if (win_start_i) held_q <= sample_i;
      if (win_end_i)   word_q <= pick_w;
    end
  end
`endif

  assign word_o = word_q;

endmodule

// File: rtl/adc_frame_capture.sv
// Arm/trigger/delay/decimate acquisition controller writing packed NCH-channel words
// to a sample RAM. Define ADC_CAPTURE_AVG_EN for boxcar averaging instead of picking.
module adc_frame_capture
  import adc_capture_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int DW     = DW_DEF,
  parameter int ADDR_W = 12
) (
  input  logic                frame_clk,
  input  logic                reset_n,
  input  logic [NCH*DW-1:0]   data_in,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig,
  input  logic [15:0]         delay_frames,
  input  logic [ADDR_W-1:0]   record_len,
  input  logic [2:0]          dec_log2,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [NCH*DW-1:0]   wr_data,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  // Write port: wr_en is a one-cycle strobe qualifying wr_addr/wr_data in that
  // same cycle; the RAM has no ready and must accept every strobe.

  cap_state_e        state_q, state_d;
  logic              trig_q;
  logic [15:0]       dly_q, dly_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [2:0]        dec_q, dec_d;
  logic [6:0]        win_q, win_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              last_q, last_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              trig_rise;
  logic              cap_active;
  logic [6:0]        win_mask;
  logic              win_start;
  logic              win_end;
  logic [ADDR_W-1:0] last_idx;

  assign trig_rise  = trig & ~trig_q;
  assign win_mask   = 7'h7f >> (3'd7 - dec_q);
  // Once the last word is formed, strobes stop so no stray write follows at D=1.
  assign cap_active = (state_q == ST_CAPTURE) && !last_q && !abort;
  assign win_start  = cap_active && (win_q == 7'd0);
  assign win_end    = cap_active && (win_q == win_mask);
  assign last_idx   = len_q - ADDR_W'(1);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    len_d     = len_q;
    dec_d     = dec_q;
    win_d     = win_q;
    idx_d     = idx_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_rise) begin
          dly_d   = delay_frames;
          len_d   = record_len;
          dec_d   = dec_log2;
          win_d   = 7'd0;
          idx_d   = '0;
          last_d  = 1'b0;
          state_d = (delay_frames == 16'd0) ? ST_CAPTURE : ST_DELAY;
        end
      end
      ST_DELAY: begin
        dly_d = dly_q - 16'd1;
        if (dly_q <= 16'd1) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (last_q) begin
          state_d = ST_DONE;
        end else if (win_end) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          idx_d     = idx_q + ADDR_W'(1);
          win_d     = 7'd0;
          if (idx_q == last_idx) last_d = 1'b1;
        end else begin
          win_d = win_q + 7'd1;
        end
      end
      ST_DONE: begin
        if (arm) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      wr_en_d = 1'b0;
      dly_d   = '0;
      win_d   = '0;
      idx_d   = '0;
      last_d  = 1'b0;
    end
  end

  assign busy_d = is_busy(state_d);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge frame_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      trig_q    <= 1'b0;
      dly_q     <= '0;
      len_q     <= '0;
      dec_q     <= '0;
      win_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig;
      dly_q     <= dly_d;
      len_q     <= len_d;
      dec_q     <= dec_d;
      win_q     <= win_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    adc_chan_decim #(
      .DW(DW)
    ) u_chan (
      .clk         (frame_clk),
      .rst_n       (reset_n),
      .sample_i    (data_in[DW*k +: DW]),
      .win_start_i (win_start),
      .win_end_i   (win_end),
`ifdef ADC_CAPTURE_AVG_EN
      .dec_log2_i  (dec_q),
`endif
      .word_o      (wr_data[DW*k +: DW])
    );
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture (ADDR_W=4); honours ADC_CAPTURE_AVG_EN.
module tb_adc_frame_capture;

  localparam int NCH = 8;
  localparam int DW = 12;
  localparam int AW = 4;
  localparam int RW = 20 + AW + NCH*DW;

  logic              frame_clk = 1'b0;
  logic              reset_n;
  logic [NCH*DW-1:0] data_in;
  logic              arm, abort, trig;
  logic [15:0]       delay_frames;
  logic [AW-1:0]     record_len;
  logic [2:0]        dec_log2;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NCH*DW-1:0] wr_data;
  logic              busy, done;
  logic [2:0]        dbg_state;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int data_mode = 0;
  int exp_done = 0;
  logic done_prev = 1'b0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] obs_q[$];
  int done_rise_q[$];

  adc_frame_capture #(.NCH(NCH), .DW(DW), .ADDR_W(AW)) dut (
    .frame_clk(frame_clk), .reset_n(reset_n), .data_in(data_in), .arm(arm),
    .abort(abort), .trig(trig), .delay_frames(delay_frames), .record_len(record_len),
    .dec_log2(dec_log2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] smp(input int c, input int k);
    if (data_mode == 1 && k == 0) return c[0] ? 12'h002 : 12'h001;
    return 12'(c + k);
  endfunction

  function automatic logic [11:0] exp_word(input int c, input int dec, input int k);
`ifdef ADC_CAPTURE_AVG_EN
    int sum = 0;
    for (int i = 0; i < (1 << dec); i++) sum += int'(smp(c + i, k));
    return 12'(sum >> dec);
`else
    return smp(c, k);
`endif
  endfunction

  // data_in driver: sample value is a function of the cycle number
  initial begin
    data_in = '0;
    forever begin
      @(posedge frame_clk);
      #1;
      for (int k = 0; k < NCH; k++) data_in[DW*k +: DW] = smp(cyc, k);
    end
  end

  // monitor
  always @(negedge frame_clk) begin
    if (wr_en) obs_q.push_back({20'(cyc), wr_addr, wr_data});
    if (done && !done_prev) done_rise_q.push_back(cyc);
    done_prev = done;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic start_capture(input int dly, input int len, input int dec, output int t);
    next_cycle();
    delay_frames = 16'(dly);
    record_len = AW'(len);
    dec_log2 = 3'(dec);
    arm = 1'b1;
    next_cycle();
    arm = 1'b0;
    next_cycle();
    trig = 1'b1;
    t = cyc;
    next_cycle();
    trig = 1'b0;
  endtask

  task automatic build_exp(input int c0, input int dec, input int len);
    int d = 1 << dec;
    int n = (len == 0) ? (1 << AW) : len;
    logic [NCH*DW-1:0] w;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < NCH; k++) w[DW*k +: DW] = exp_word(c0 + j*d, dec, k);
      exp_q.push_back({20'(c0 + (j+1)*d), AW'(j), w});
    end
    exp_done = c0 + n*d + 1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) next_cycle();
    check_eq({tag, "_done_seen"}, 128'(done), 128'(1));
    repeat (4) next_cycle();
  endtask

  task automatic compare_writes(input string tag, input int base);
    int n = obs_q.size() - base;
    check_eq({tag, "_wr_count"}, 128'(n), 128'(exp_q.size()));
    for (int i = 0; i < n && exp_q.size() > 0; i++)
      check_eq({tag, "_wr"}, 128'(obs_q[base + i]), 128'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  task automatic check_done_cyc(input string tag, input int dbase);
    int got = (done_rise_q.size() > dbase) ? done_rise_q[dbase] : -1;
    check_eq(tag, 128'(got), 128'(exp_done));
  endtask

  task automatic do_abort();
    next_cycle();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
  endtask

  initial begin
    int t, base, dbase;
    reset_n = 1'b0;
    arm = 1'b0; abort = 1'b0; trig = 1'b0;
    delay_frames = '0; record_len = '0; dec_log2 = '0;
    repeat (3) next_cycle();
    check_eq("rst_wr_en", 128'(wr_en), 128'(0));
    check_eq("rst_wr_addr", 128'(wr_addr), 128'(0));
    check_eq("rst_wr_data", 128'(wr_data), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_state", 128'(dbg_state), 128'(0));
    reset_n = 1'b1;
    repeat (2) next_cycle();

    // delay 0, D=1, len 4, ramp: writes T+2..T+5, done T+6
    data_mode = 0;
    base = obs_q.size(); dbase = done_rise_q.size();
    start_capture(0, 4, 0, t);
    build_exp(t + 1, 0, 4);
    check_eq("t1_first_wr_cyc", 128'(exp_q[0][RW-1 -: 20]), 128'(t + 2));
    wait_done("t1", 40);
    compare_writes("t1", base);
    check_done_cyc("t1_done_cyc", dbase);
    check_eq("t1_busy_after", 128'(busy), 128'(0));

    // delay 3, D=4, len 2: writes T+8, T+12, done T+13
    base = obs_q.size(); dbase = done_rise_q.size();
    start_capture(3, 2, 2, t);
    build_exp(t + 4, 2, 2);
    wait_done("t2", 60);
    check_eq("t2_wr0_cyc", 128'(obs_q.size() > base ? int'(obs_q[base][RW-1 -: 20]) : -1), 128'(t + 8));
    check_eq("t2_wr1_cyc", 128'(obs_q.size() > base + 1 ? int'(obs_q[base+1][RW-1 -: 20]) : -1), 128'(t + 12));
    compare_writes("t2", base);
    check_done_cyc("t2_done_cyc", dbase);
    check_eq("t2_done_hand", 128'(exp_done), 128'(t + 13));

    // channel 0 alternating 1/2, D=2
    data_mode = 1;
    base = obs_q.size(); dbase = done_rise_q.size();
    start_capture(0, 2, 1, t);
    build_exp(t + 1, 1, 2);
    wait_done("t3", 40);
`ifdef ADC_CAPTURE_AVG_EN
    check_eq("t3_ch0_hand", 128'(obs_q.size() > base ? obs_q[base][11:0] : 12'hfff), 128'(12'h001));
`else
    check_eq("t3_ch0_hand", 128'(obs_q.size() > base ? obs_q[base][11:0] : 12'hfff),
             128'((t + 1) % 2 == 1 ? 12'h002 : 12'h001));
`endif
    compare_writes("t3", base);
    data_mode = 0;

    // arm while trig held high: no capture
    do_abort();
    base = obs_q.size();
    next_cycle(); trig = 1'b1;
    next_cycle(); arm = 1'b1;
    next_cycle(); arm = 1'b0;
    repeat (10) next_cycle();
    check_eq("held_trig_state", 128'(dbg_state), 128'(1));
    check_eq("held_trig_busy", 128'(busy), 128'(1));
    check_eq("held_trig_wr", 128'(obs_q.size() - base), 128'(0));
    trig = 1'b0;
    do_abort();

    // abort in DELAY
    base = obs_q.size();
    start_capture(20, 4, 0, t);
    check_eq("abort_in_delay", 128'(dbg_state), 128'(2));
    do_abort();
    check_eq("abort_state", 128'(dbg_state), 128'(0));
    check_eq("abort_busy", 128'(busy), 128'(0));
    repeat (30) next_cycle();
    check_eq("abort_wr", 128'(obs_q.size() - base), 128'(0));

    // record_len 0 -> 16 words, addresses 0..15
    base = obs_q.size(); dbase = done_rise_q.size();
    start_capture(0, 0, 0, t);
    build_exp(t + 1, 0, 0);
    wait_done("t5", 60);
    check_eq("t5_last_addr", 128'(obs_q.size() > base + 15 ? int'(obs_q[base+15][NCH*DW +: AW]) : -1), 128'(15));
    compare_writes("t5", base);
    check_done_cyc("t5_done_cyc", dbase);

    // arm during CAPTURE ignored, then arm in DONE re-arms
    base = obs_q.size(); dbase = done_rise_q.size();
    start_capture(0, 4, 1, t);
    build_exp(t + 1, 1, 4);
    next_cycle(); arm = 1'b1;
    next_cycle(); arm = 1'b0;
    wait_done("t6", 60);
    compare_writes("t6", base);
    check_done_cyc("t6_done_cyc", dbase);
    check_eq("t6_done_hand", 128'(exp_done), 128'(t + 10));
    next_cycle(); arm = 1'b1;
    next_cycle(); arm = 1'b0;
    check_eq("rearm_done", 128'(done), 128'(0));
    check_eq("rearm_busy", 128'(busy), 128'(1));
    check_eq("rearm_state", 128'(dbg_state), 128'(1));
    do_abort();

    // reset mid-capture
    start_capture(0, 8, 1, t);
    repeat (5) next_cycle();
    check_eq("pre_rst_capture", 128'(dbg_state), 128'(3));
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_wr_en", 128'(wr_en), 128'(0));
    check_eq("midrst_wr_addr", 128'(wr_addr), 128'(0));
    check_eq("midrst_wr_data", 128'(wr_data), 128'(0));
    check_eq("midrst_busy", 128'(busy), 128'(0));
    check_eq("midrst_done", 128'(done), 128'(0));
    next_cycle();
    #2;
    reset_n = 1'b1;
    base = obs_q.size();
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      trig = i[1];
    end
    trig = 1'b0;
    check_eq("postrst_wr", 128'(obs_q.size() - base), 128'(0));
    check_eq("postrst_state", 128'(dbg_state), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
